// File: rtl/pd_hash_ser_pkg.sv
// Shared definitions for the hash serializer: frame state encoding and default trailer word.
package pd_hash_ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK,
        ST_SYNC,
        ST_DONE
    } ser_state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h5400;

endpackage

// File: rtl/pd_hash_word_mux.sv
// Output word select: shadow word at the current index, the checksum, or the sync trailer.
module pd_hash_word_mux
    import pd_hash_ser_pkg::*;
#(
    parameter int                WORD_W    = 16,
    parameter int                NUM_WORDS = 16,
    parameter int                IDX_W     = 4,
    parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(SYNC_WORD_DEFAULT)
) (
    input  ser_state_t                    state,
    input  logic [IDX_W-1:0]              idx,
    input  logic [NUM_WORDS*WORD_W-1:0]   shadow,
    input  logic [WORD_W-1:0]             acc,
    output logic [WORD_W-1:0]             data
);

    always_comb begin
        data = '0;
        case (state)
            ST_DATA:  data = shadow[32'(idx) * WORD_W +: WORD_W];
            ST_CHECK: data = acc;
            ST_SYNC:  data = SYNC_WORD;
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/pd_hash_serializer.sv
// Streams a latched hash into the packet FIFO one word per accepted write, then a sync word.
// Define PD_HASH_SER_CHECKSUM_EN to insert an XOR checksum word between the data and the sync word.
module pd_hash_serializer
    import pd_hash_ser_pkg::*;
#(
    parameter int                WORD_W    = 16,
    parameter int                NUM_WORDS = 16,
    parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(SYNC_WORD_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic [NUM_WORDS*WORD_W-1:0]   hash,
    input  logic                          fifo_full,
    output logic                          write_fifo,
    output logic [WORD_W-1:0]             write_data,
    output logic                          busy,
    output logic                          done
);

    localparam int               IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    ser_state_t                  state;
    logic [IDX_W-1:0]            idx;
    logic [NUM_WORDS*WORD_W-1:0] shadow;
    logic [WORD_W-1:0]           acc;
    logic                        accepted;

    // Writes are offered in every emitting state; the FIFO's full flag gates them with no skid buffer.
    assign write_fifo = (state == ST_DATA || state == ST_CHECK || state == ST_SYNC) && !fifo_full;
    assign accepted   = write_fifo;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

`ifndef PD_HASH_SER_CHECKSUM_EN
    assign acc = '0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            shadow <= '0;
`ifdef PD_HASH_SER_CHECKSUM_EN
            acc    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shadow <= hash;
                        idx    <= '0;
`ifdef PD_HASH_SER_CHECKSUM_EN
                        acc    <= '0;
`endif
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accepted) begin
`ifdef PD_HASH_SER_CHECKSUM_EN
                        acc <= acc ^ write_data;
`endif
                        // Index parks on the last word instead of wrapping.
                        if (idx == LAST_IDX) begin
`ifdef PD_HASH_SER_CHECKSUM_EN
                            state <= ST_CHECK;
`else
                            state <= ST_SYNC;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accepted) state <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (accepted) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    pd_hash_word_mux #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_word_mux (
        .state  (state),
        .idx    (idx),
        .shadow (shadow),
        .acc    (acc),
        .data   (write_data)
    );

endmodule

// File: tb/tb_pd_hash_serializer.sv
// Directed bench: default 16x16 instance driven from a cycle vector table, plus a 32x8 override instance.
module tb_pd_hash_serializer;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         fifo_full = 1'b0;
    logic [255:0] hash;
    logic         write_fifo, busy, done;
    logic [15:0]  write_data;

    logic         start2 = 1'b0;
    logic         fifo_full2 = 1'b0;
    logic [255:0] hash2;
    logic         write_fifo2, busy2, done2;
    logic [31:0]  write_data2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pd_hash_serializer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .hash       (hash),
        .fifo_full  (fifo_full),
        .write_fifo (write_fifo),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    pd_hash_serializer #(
        .WORD_W    (32),
        .NUM_WORDS (8),
        .SYNC_WORD (32'hA5A5_5A5A)
    ) dut2 (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start2),
        .hash       (hash2),
        .fifo_full  (fifo_full2),
        .write_fifo (write_fifo2),
        .write_data (write_data2),
        .busy       (busy2),
        .done       (done2)
    );

    typedef struct {
        logic        start;
        logic        full;
        logic        zero_hash;
        logic        exp_wr;
        logic [15:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

`ifdef PD_HASH_SER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic void push(input logic st, input logic fl, input logic zh, input logic wr,
                                 input logic [15:0] d, input logic b, input logic dn);
        vec_t v;
        v.start = st; v.full = fl; v.zero_hash = zh; v.exp_wr = wr;
        v.exp_data = d; v.exp_busy = b; v.exp_done = dn;
        vecs.push_back(v);
    endfunction

    function automatic logic [255:0] default_hash();
        logic [255:0] h;
        for (int i = 0; i < 16; i++) h[i*16 +: 16] = 16'(i + 1);
        return h;
    endfunction

    // Pulse start on the default instance and expect an unstalled frame on consecutive cycles.
    task automatic run_default_frame(input string tag);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            check({tag, "_wr"}, 32'(write_fifo), 32'd1);
            check({tag, "_data"}, 32'(write_data), 32'(j + 1));
        end
        if (CSUM) begin
            @(negedge clk);
            check({tag, "_csum"}, 32'(write_data), 32'h0010);
        end
        @(negedge clk);
        check({tag, "_sync"}, 32'(write_data), 32'h5400);
        check({tag, "_sync_wr"}, 32'(write_fifo), 32'd1);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] words2 [8];
        logic [31:0] xor2;
        int  cnt;
        bit  found;

        hash = default_hash();
        words2 = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                   32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        xor2 = '0;
        for (int i = 0; i < 8; i++) begin
            hash2[i*32 +: 32] = words2[i];
            xor2 ^= words2[i];
        end

        // Frame with a mid-frame start + hash wipe, a 3-cycle stall on word 5, and start during DONE.
        push(1, 0, 0, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) for (int s = 0; s < 3; s++) push(0, 1, 0, 0, 16'h0006, 1, 0);
            push(i == 3, 0, i == 3, 1, 16'(i + 1), 1, 0);
        end
        if (CSUM) push(0, 0, 0, 1, 16'h0010, 1, 0);
        push(0, 0, 0, 1, 16'h5400, 1, 0);
        push(1, 0, 0, 0, 16'h0000, 1, 1);
        push(0, 0, 0, 0, 16'h0000, 0, 0);
        push(0, 0, 0, 0, 16'h0000, 0, 0);

        #12;
        check("rst_wr",    32'(write_fifo), 32'd0);
        check("rst_data",  32'(write_data), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst2_wr",   32'(write_fifo2), 32'd0);
        check("rst2_data", write_data2, 32'd0);
        @(negedge clk) n_rst = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            @(posedge clk); #1;
            start     = vecs[v].start;
            fifo_full = vecs[v].full;
            if (vecs[v].zero_hash) hash = '0;
            @(negedge clk);
            check($sformatf("vec%0d_wr", v),   32'(write_fifo), 32'(vecs[v].exp_wr));
            check($sformatf("vec%0d_busy", v), 32'(busy),       32'(vecs[v].exp_busy));
            check($sformatf("vec%0d_done", v), 32'(done),       32'(vecs[v].exp_done));
            if (vecs[v].exp_wr || (vecs[v].exp_busy && !vecs[v].exp_done))
                check($sformatf("vec%0d_data", v), 32'(write_data), 32'(vecs[v].exp_data));
        end
        hash = default_hash();

        // Done is counted in clock edges from the cycle start is driven to the cycle done is high.
        @(posedge clk); #1 start = 1'b1;
        cnt = 0;
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1 start = 1'b0;
            cnt++;
            @(negedge clk);
            if (done) begin found = 1'b1; break; end
        end
        check("lat_found", 32'(found), 32'd1);
        check("lat_cycles", 32'(cnt), CSUM ? 32'd19 : 32'd18);
        @(negedge clk);
        check("lat_done_1cyc", 32'(done), 32'd0);
        check("lat_idle", 32'(busy), 32'd0);

        // Reset asserted mid-frame while word 8 is on the bus.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (write_fifo && write_data == 16'h0009) begin found = 1'b1; break; end
        end
        check("rstmid_reach_w8", 32'(found), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("rstmid_wr",   32'(write_fifo), 32'd0);
        check("rstmid_data", 32'(write_data), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        @(posedge clk); #1 n_rst = 1'b1;
        @(negedge clk);
        check("rstmid_stay_idle", 32'(busy), 32'd0);
        run_default_frame("fresh");

        // Parameter override instance: 8 x 32-bit words, custom sync word.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check($sformatf("p32_wr%0d", j), 32'(write_fifo2), 32'd1);
            check($sformatf("p32_data%0d", j), write_data2, words2[j]);
        end
        if (CSUM) begin
            @(negedge clk);
            check("p32_csum", write_data2, xor2);
        end
        @(negedge clk);
        check("p32_sync", write_data2, 32'hA5A5_5A5A);
        @(negedge clk);
        check("p32_done", 32'(done2), 32'd1);
        check("p32_done_nowr", 32'(write_fifo2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pd_hash_serializer.md
# pd_hash_serializer

Parametrised serializer that takes a wide hash result from the miner core and streams it into the output FIFO, one word per accepted write, followed by a sync word. It replaces the fixed 16×16-bit separator with a configurable word width and word count, a start/busy/done handshake, FIFO back-pressure, and an optional XOR checksum word. It sits between the hash-compare stage and the outbound packet FIFO.

## Interface
Parameters:
- WORD_W, 16: width of each emitted word in bits.
- NUM_WORDS, 16: number of data words per hash. Must be ≥ 2.
- SYNC_WORD, 16'h5400: trailer word, WORD_W bits wide.

Ports:
- clk, input, 1: system clock, rising edge.
- n_rst, input, 1: asynchronous active-low reset.
- start, input, 1: request to serialize `hash`. Sampled only in IDLE.
- hash, input, NUM_WORDS*WORD_W: hash to serialize. Word i is bits [i*WORD_W +: WORD_W].
- fifo_full, input, 1: the downstream FIFO cannot accept a write this cycle.
- write_fifo, output, 1: write strobe to the FIFO.
- write_data, output, WORD_W: word being written, valid while write_fifo = 1.
- busy, output, 1: a frame is in progress (not IDLE).
- done, output, 1: one-cycle pulse after the sync word has been written.

## Operation
- States: IDLE, DATA, CHECK, SYNC, DONE.
- IDLE:
  - start = 1 latches `hash` into a shadow register, clears the word index and the checksum accumulator, then moves to DATA.
  - start = 0 stays in IDLE.
- DATA: emits the shadow word at the current index.
  - On an accepted write, the index increments and the word is XORed into the accumulator.
  - After the accepted write at index NUM_WORDS-1, goes to CHECK if the checksum is enabled, otherwise to SYNC.
- CHECK: emits the accumulator value. After the accepted write, goes to SYNC.
- SYNC: emits SYNC_WORD. After the accepted write, goes to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Accepted write: write_fifo = 1 in a cycle where fifo_full = 0.
- write_fifo = (state ∈ {DATA, CHECK, SYNC}) && !fifo_full. This is combinational from registered state and fifo_full only.
- write_data is muxed from registered state, index, shadow and accumulator. It holds its value while stalled.
- While fifo_full = 1, state, index and accumulator hold. No word is skipped or duplicated.
- start while busy is ignored and is not queued. Changes to `hash` after latching have no effect on the frame.
- start in the DONE cycle is ignored; only IDLE samples start.
- Index counter width is $clog2(NUM_WORDS). It never wraps past NUM_WORDS-1.

## Timing
- Reset values: write_fifo = 0, write_data = 0, busy = 0, done = 0, state = IDLE, index = 0, accumulator = 0, shadow = 0.
- Reset asserted mid-frame aborts the frame immediately, with no sync word. The FIFO owner discards the partial frame.
- start sampled high at edge k gives busy = 1 and the first write_fifo opportunity in the cycle after edge k.
- With no back-pressure, a frame occupies NUM_WORDS + 1 (+1 with checksum) consecutive write cycles, followed by one DONE cycle.
- Default configuration, checksum off: start-to-done = 18 cycles. The earliest next start is sampled in the cycle after done.
- fifo_full is sampled in the same cycle as write_fifo is evaluated. There is no skid buffer.

## Configuration
- PD_HASH_SER_CHECKSUM_EN defined:
  - the CHECK state and the accumulator are compiled in;
  - the frame is data words, then the XOR of all data words, then SYNC_WORD.
- PD_HASH_SER_CHECKSUM_EN undefined:
  - CHECK and the accumulator are removed;
  - the frame is data words, then SYNC_WORD.

## Structure
- Shared package pd_hash_ser_pkg contains:
  - the state enum typedef (IDLE, DATA, CHECK, SYNC, DONE);
  - the default SYNC_WORD constant 16'h5400.
- One sub-module, pd_hash_word_mux: combinational selection of shadow word i, or checksum, or sync, by state and index. The top level holds the FSM, the shadow register, the index counter and the accumulator.

## Test plan
Shared stimulus: NUM_WORDS = 16, WORD_W = 16, hash word i = i+1, so word 0 = 16'h0001 and word 15 = 16'h0010.
- Checksum off, fifo_full = 0, pulse start -> write_data = 16'h0001..16'h0010 on 16 consecutive writes, then 16'h5400, then done pulses; 18 cycles from start to done.
- Checksum on, same stimulus -> 16 data words, then 16'h0010 (XOR of 1..16), then 16'h5400, then done.
- fifo_full held high for 3 cycles during word 5 (16'h0006) -> write_fifo = 0 for those cycles; 16'h0006 is written exactly once, then 16'h0007 follows.
- start pulsed again and `hash` changed to all-zero mid-frame -> the original frame completes unchanged and no second frame starts.
- n_rst asserted during word 8 -> all outputs 0 immediately; after release with start, a full fresh frame is emitted starting at 16'h0001.
- Parameter override WORD_W = 32, NUM_WORDS = 8, SYNC_WORD = 32'hA5A5_5A5A -> 8 words, then 32'hA5A5_5A5A, then done; the 8 words are 256-bit hash 32'hba7816bf..32'hf20015ad in little-word order, word 0 = 32'hba7816bf.
